// File: rtl/rca_pipe_addsub.sv
// Pipelined ripple-carry add/subtract unit.
// The WIDTH-bit operation is cut into STAGES equal slices. Slice k is added in
// pipeline stage k using the carry registered by stage k-1. Untouched upper
// operand slices ride along, and finished lower sum slices are carried forward,
// so the full result leaves the last stage aligned. The last stage register is
// the output register.
//
// Handshake (valid/ready): a beat transfers on a rising clk edge exactly when
// valid && ready are both high in the preceding cycle. A producer holding valid
// high keeps its payload stable until the transfer. in_ready depends only on
// out_valid and out_ready (global stall), never on in_valid.
module rca_pipe_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] ain,
    input  logic [WIDTH-1:0] bin,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out,
    output logic             ovf_out
);

    localparam int S = WIDTH / STAGES;

    // Whole pipeline moves together; it only freezes when a result is waiting
    // at the output and the consumer is not taking it.
    logic advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Stage registers
        logic             v_q;
        logic             sub_q;
        logic             c_q;
        logic             o_q;
        logic [WIDTH-1:0] a_q;
        logic [WIDTH-1:0] b_q;
        logic [WIDTH-1:0] s_q;

        // Values entering this stage
        logic             v_in;
        logic             sub_in;
        logic             c_in;
        logic [WIDTH-1:0] a_in;
        logic [WIDTH-1:0] b_in;
        logic [WIDTH-1:0] s_in;

        // Slice arithmetic
        logic [S-1:0]     a_sl;
        logic [S-1:0]     b_sl;
        logic [S-1:0]     r_sl;
        logic             co;
        logic             ci_msb;
        logic [WIDTH-1:0] s_nx;

        if (k == 0) begin : g_head
            // Slice 0 takes the effective carry-in: borrow-in is inverted for subtract.
            assign v_in   = in_valid;
            assign sub_in = sub;
            assign c_in   = sub ? ~cin : cin;
            assign a_in   = ain;
            assign b_in   = bin;
            assign s_in   = '0;
        end else begin : g_body
            assign v_in   = g_stage[k-1].v_q;
            assign sub_in = g_stage[k-1].sub_q;
            assign c_in   = g_stage[k-1].c_q;
            assign a_in   = g_stage[k-1].a_q;
            assign b_in   = g_stage[k-1].b_q;
            assign s_in   = g_stage[k-1].s_q;
        end

        // Ripple-add this stage's slice and merge it into the forwarded sum.
        always_comb begin
            a_sl = a_in[k*S +: S];
            b_sl = sub_in ? ~b_in[k*S +: S] : b_in[k*S +: S];
            {co, r_sl} = {1'b0, a_sl} + {1'b0, b_sl} + {{S{1'b0}}, c_in};
            // Carry into the slice MSB recovered from the MSB sum bit.
            ci_msb = a_sl[S-1] ^ b_sl[S-1] ^ r_sl[S-1];
            s_nx = s_in;
            s_nx[k*S +: S] = r_sl;
        end

        // Stage register: clears on reset, shifts on advance, holds on stall.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                v_q   <= 1'b0;
                sub_q <= 1'b0;
                c_q   <= 1'b0;
                o_q   <= 1'b0;
                a_q   <= '0;
                b_q   <= '0;
                s_q   <= '0;
            end else if (advance) begin
                v_q   <= v_in;
                sub_q <= sub_in;
                c_q   <= co;
                o_q   <= ci_msb ^ co;
                a_q   <= a_in;
                b_q   <= b_in;
                s_q   <= s_nx;
            end
        end

        // Operand copies in the last stage and overflow bits of inner stages
        // are never consumed; fold them into one sink.
        logic unused_stage;
        assign unused_stage = ^{a_q, b_q, sub_q, o_q};
    end

    assign advance   = !g_stage[STAGES-1].v_q || out_ready;
    assign in_ready  = advance;
    assign out_valid = g_stage[STAGES-1].v_q;
    assign sum_out   = g_stage[STAGES-1].s_q;
    assign cout_out  = g_stage[STAGES-1].c_q;
    assign ovf_out   = g_stage[STAGES-1].o_q;

endmodule

// File: tb/tb_rca_pipe_addsub.sv
// Self-checking bench for rca_pipe_addsub (16/4 main instance, 4/1 small instance).
module tb_rca_pipe_addsub;

    localparam int W = 16;
    localparam int N = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main DUT ----------------
    logic         in_valid, in_ready, cin, sub, out_valid, out_ready, cout_out, ovf_out;
    logic [W-1:0] ain, bin, sum_out;

    rca_pipe_addsub #(.WIDTH(W), .STAGES(N)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .ain(ain), .bin(bin), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum_out(sum_out), .cout_out(cout_out), .ovf_out(ovf_out)
    );

    // ---------------- small DUT (4-bit, single stage) ----------------
    logic       in_valid1, in_ready1, cin1, sub1, out_valid1, out_ready1, cout1, ovf1;
    logic [3:0] a1, b1, sum1;

    rca_pipe_addsub #(.WIDTH(4), .STAGES(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .ain(a1), .bin(b1), .cin(cin1), .sub(sub1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .sum_out(sum1), .cout_out(cout1), .ovf_out(ovf1)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [W+1:0] exp_q[$];       // {cout, ovf, sum}
    int           acc_cyc_q[$];   // cycle index of acceptance
    int           acc_stall_q[$]; // stall total at acceptance
    int           cyc = 0;
    int           stall_total = 0;
    int           stall_left = 0;
    logic         saw_stall = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic logic [W+1:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic c, input logic s);
        longint ua, ub, sa, sb, cc, r, sr, lim;
        logic   co, ov;
        ua  = longint'(a);
        ub  = longint'(b);
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        cc  = c ? 64'sd1 : 64'sd0;
        lim = longint'(1) <<< (W - 1);
        if (s) begin
            r  = ua - ub - cc;
            co = (r >= 0);
            sr = sa - sb - cc;
        end else begin
            r  = ua + ub + cc;
            co = (r >= (longint'(1) <<< W));
            sr = sa + sb + cc;
        end
        ov = (sr >= lim) || (sr < -lim);
        return {co, ov, r[W-1:0]};
    endfunction

    // ---------------- driver tasks ----------------
    // One cycle, entered just after a falling edge.
    task automatic step(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic s, output logic accepted);
        logic [W+1:0] e;
        int ac, st;
        in_valid  = iv;
        ain       = a;
        bin       = b;
        cin       = c;
        sub       = s;
        out_ready = (stall_left == 0);
        if (stall_left > 0) stall_left--;
        #1;
        accepted = iv && in_ready;
        check_val("in_ready", in_ready, !out_valid || out_ready);
        if (!in_ready) saw_stall = 1'b1;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_beat", out_valid, 1'b0);
            end else begin
                e  = exp_q.pop_front();
                ac = acc_cyc_q.pop_front();
                st = acc_stall_q.pop_front();
                check_val("result", {cout_out, ovf_out, sum_out}, e);
                check_val("latency", cyc - ac, N + stall_total - st);
            end
        end
        if (accepted) begin
            exp_q.push_back(ref_model(a, b, c, s));
            acc_cyc_q.push_back(cyc);
            acc_stall_q.push_back(stall_total);
        end
        if (!in_ready) stall_total++;
        cyc++;
        @(negedge clk);
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic s);
        logic acc;
        int tries;
        tries = 0;
        acc = 1'b0;
        while (!acc && tries < 20) begin
            step(1'b1, a, b, c, s, acc);
            tries++;
        end
        check_val("accept_timeout", acc, 1'b1);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 16'($urandom), 16'($urandom), 1'b0, 1'b0, acc);
    endtask

    task automatic drain();
        logic acc;
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 60) begin
            step(1'b0, '0, '0, 1'b0, 1'b0, acc);
            t++;
        end
        check_val("drain", exp_q.size(), 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic acc;
        logic [W-1:0] ra, rb;
        in_valid = 1'b0; ain = '0; bin = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0; out_ready1 = 1'b1;

        // Reset held for 3 cycles.
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check_val("rst_out_valid", out_valid, 1'b0);
        check_val("rst_sum", sum_out, 16'h0000);
        check_val("rst_cout", cout_out, 1'b0);
        check_val("rst_ovf", ovf_out, 1'b0);
        check_val("rst_in_ready", in_ready, 1'b1);
        check_val("rst_out_valid1", out_valid1, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // 4-bit single-stage: 1010 + 1111 -> 1001, cout=1, ovf=0 after one edge.
        in_valid1 = 1'b1; a1 = 4'b1010; b1 = 4'b1111; cin1 = 1'b0; sub1 = 1'b0;
        step(1'b0, '0, '0, 1'b0, 1'b0, acc);
        in_valid1 = 1'b0;
        check_val("w4_valid", out_valid1, 1'b1);
        check_val("w4_sum", sum1, 4'b1001);
        check_val("w4_cout", cout1, 1'b1);
        check_val("w4_ovf", ovf1, 1'b0);

        // Carry through every slice.
        send(16'hFFFF, 16'h0000, 1'b1, 1'b0);
        drain();

        // Signed overflow on subtract.
        send(16'h8000, 16'h0001, 1'b0, 1'b1);
        drain();

        // Eight back-to-back beats with a 3-cycle output stall mid-stream.
        saw_stall = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 5) stall_left = 3;
            ra = 16'($urandom);
            rb = 16'($urandom);
            send(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        drain();
        check_val("in_ready_dropped", saw_stall, 1'b1);

        // Random traffic with gaps and random stalls, plus corner operands.
        for (int i = 0; i < 60; i++) begin
            if (stall_left == 0 && $urandom_range(0, 7) == 0) stall_left = $urandom_range(1, 3);
            case ($urandom_range(0, 5))
                0: ra = 16'h7FFF;
                1: ra = 16'h8000;
                default: ra = 16'($urandom);
            endcase
            rb = ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'($urandom);
            if ($urandom_range(0, 3) != 0) send(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else step(1'b0, ra, rb, 1'b0, 1'b0, acc);
        end
        drain();

        // Asynchronous reset with beats in flight.
        stall_left = 0;
        send(16'h1234, 16'h1111, 1'b0, 1'b0);
        send(16'h4321, 16'h0101, 1'b1, 1'b1);
        send(16'hABCD, 16'h00FF, 1'b1, 1'b0);
        idle(1);
        check_val("pre_reset_valid", out_valid, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check_val("async_rst_valid", out_valid, 1'b0);
        check_val("async_rst_sum", sum_out, 16'h0000);
        check_val("async_rst_cout", cout_out, 1'b0);
        check_val("async_rst_ovf", ovf_out, 1'b0);
        check_val("async_rst_in_ready", in_ready, 1'b1);
        exp_q.delete();
        acc_cyc_q.delete();
        acc_stall_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, '0, '0, 1'b0, 1'b0, acc);
            check_val("no_stale", out_valid, 1'b0);
        end

        // Normal operation resumes right after reset release.
        send(16'h0F0F, 16'hF0F1, 1'b0, 1'b0);
        send(16'h0003, 16'h0005, 1'b1, 1'b1);
        drain();

        check_val("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
